seq_divider: RTL and testbench

Unsigned restoring sequential divider sitting directly downstream of the vector-divide control FSM and its X/Y operand registers. It consumes the start_div/stop_div pulses and dividend/divisor operands. It produces quotient and rest registers that the datapath write-data mux feeds back to RAM. One quotient bit is resolved per clock, so a division takes NBITS cycles.

---
 rtl/vd_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 29 ++
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vd_pkg.sv
// Shared definitions for the vector-divide control FSM, datapath and divider.
package vd_pkg;

    // Default operand/result width of the divide datapath.
    localparam int unsigned VD_NBITS = 32;

    // Divider state encoding, also decoded by the control FSM.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_HOLD = 2'b10
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit one quotient bit.
module seq_divider_div_step
    import vd_pkg::*;
#(
    parameter int unsigned NBITS = VD_NBITS
) (
    input  logic [NBITS-1:0] i_rem,
    input  logic [NBITS-1:0] i_q,
    input  logic [NBITS-1:0] i_d,
    output logic [NBITS-1:0] o_rem,
    output logic [NBITS-1:0] o_q
);

    logic [NBITS:0]   w_trial;
    logic [NBITS-1:0] w_diff;
    logic             w_fits;

    // Trial value keeps the carry bit so large divisors compare correctly.
    always_comb begin
        w_trial = {i_rem, i_q[NBITS-1]};
        w_fits  = (w_trial >= {1'b0, i_d});
        // When the divisor fits the true difference is below 2^NBITS.
        w_diff  = w_trial[NBITS-1:0] - i_d;
        o_rem   = w_fits ? w_diff : w_trial[NBITS-1:0];
        o_q     = {i_q[NBITS-2:0], w_fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring sequential divider, one quotient bit per clock.
// start captures operands and runs NBITS iterations; the result is held until
// stop publishes it to the quotient/rest/dbz registers with a one-cycle valid.
module seq_divider
    import vd_pkg::*;
#(
    parameter  int unsigned NBITS = VD_NBITS,
    localparam int unsigned CNT_W = $clog2(NBITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] rest,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             dbz
);

    div_state_e       r_state;
    div_state_e       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [NBITS-1:0] r_rem;
    logic [NBITS-1:0] r_q;
    logic [NBITS-1:0] r_d;
    logic             r_zero;
    logic [NBITS-1:0] r_quot;
    logic [NBITS-1:0] r_rest;
    logic             r_dbz;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [NBITS-1:0] w_step_rem;
    logic [NBITS-1:0] w_step_q;
    logic             w_last;
    logic             w_publish;
    logic             w_busy_d;
    logic             w_done_d;

    seq_divider_div_step #(
        .NBITS (NBITS)
    ) u_div_step (
        .i_rem (r_rem),
        .i_q   (r_q),
        .i_d   (r_d),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    assign w_last    = (r_cnt == CNT_W'(NBITS - 1));
    // A stop only counts when a finished result is held.
    assign w_publish = (r_state == DIV_HOLD) && stop;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state: start wins from any state and restarts the division.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            DIV_RUN: begin
                if (w_last) begin
                    w_state_d = DIV_HOLD;
                end
            end
            default: begin
                w_state_d = r_state;
            end
        endcase
        if (start) begin
            w_state_d = DIV_RUN;
        end
    end

    // Status outputs decoded from the next state so they come straight from flops.
    always_comb begin
        w_busy_d = (w_state_d == DIV_RUN);
        w_done_d = (w_state_d == DIV_HOLD);
    end

    // Status and valid pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_valid <= w_publish;
        end
    end

    // Iteration datapath: capture on start, one restoring step per RUN cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_zero <= 1'b0;
        end else if (start) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_q    <= dividend;
            r_d    <= divisor;
            r_zero <= (divisor == '0);
        end else if (r_state == DIV_RUN) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_rem  <= w_step_rem;
            r_q    <= w_step_q;
        end
    end

    // Published result: sampled from the held iteration registers on stop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_quot <= '0;
            r_rest <= '0;
            r_dbz  <= 1'b0;
        end else if (w_publish) begin
            r_quot <= r_q;
            r_rest <= r_rem;
            r_dbz  <= r_zero;
        end
    end

    assign quotient = r_quot;
    assign rest     = r_rest;
    assign dbz      = r_dbz;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results when it
// issues an accepted stop; a negedge monitor pops and compares on every valid.
module tb_seq_divider;

    localparam int unsigned NB = 32;

    typedef struct packed {
        logic [NB-1:0] q;
        logic [NB-1:0] r;
        logic          z;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic          stop;
    logic [NB-1:0] dividend;
    logic [NB-1:0] divisor;
    logic [NB-1:0] quotient;
    logic [NB-1:0] rest;
    logic          busy;
    logic          done;
    logic          valid;
    logic          dbz;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    seq_divider #(
        .NBITS (NB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .rest     (rest),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .dbz      (dbz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start for one cycle, then scramble operands to prove they are not re-sampled.
    task automatic do_start(input logic [NB-1:0] a, input logic [NB-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic do_stop(input logic [NB-1:0] q, input logic [NB-1:0] r, input logic z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        exp_q.push_back(e);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("valid_one_cycle", {31'b0, valid}, 32'd0);
    endtask

    // Count cycles until done rises; a bounded wait that fails on expiry.
    task automatic wait_hold(input string name, input int exp_cyc);
        int n;
        n = 0;
        while (!done && n < 100) begin
            check({name, "_busy"}, {31'b0, busy}, 32'd1);
            tick();
            n++;
        end
        check({name, "_latency"}, n, exp_cyc);
        check({name, "_busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    // Monitor: compare every published result against the scoreboard.
    always @(negedge clock) begin
        if (!reset && valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'b0, valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", quotient, e.q);
                check("rest", rest, e.r);
                check("dbz", {31'b0, dbz}, {31'b0, e.z});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state.
        check("rst_quotient", quotient, 32'd0);
        check("rst_rest", rest, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_dbz", {31'b0, dbz}, 32'd0);

        // 100 / 7, then republish the same held result.
        do_start(32'd100, 32'd7);
        wait_hold("t1", NB);
        do_stop(32'd14, 32'd2, 1'b0);
        check("t1_done_held", {31'b0, done}, 32'd1);
        do_stop(32'd14, 32'd2, 1'b0);

        // 0xFFFFFFFF / 1, then 5 / 9 started in the same cycle as its stop.
        do_start(32'hFFFF_FFFF, 32'd1);
        wait_hold("t2a", NB);
        exp_q.push_back('{q: 32'hFFFF_FFFF, r: 32'd0, z: 1'b0});
        start    = 1'b1;
        stop     = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd9;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_hold("t2b", NB);
        do_stop(32'd0, 32'd5, 1'b0);

        // Divide by zero.
        do_start(32'd1234, 32'd0);
        wait_hold("t3", NB);
        do_stop(32'hFFFF_FFFF, 32'd1234, 1'b1);

        // Early stop during RUN is ignored; later stop publishes.
        do_start(32'd77, 32'd5);
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("t4_no_valid", {31'b0, valid}, 32'd0);
        check("t4_quot_kept", quotient, 32'hFFFF_FFFF);
        check("t4_rest_kept", rest, 32'd1234);
        check("t4_dbz_kept", {31'b0, dbz}, 32'd1);
        wait_hold("t4", NB - 11);
        do_stop(32'd15, 32'd2, 1'b0);

        // Restart mid-RUN discards the first division.
        do_start(32'd50, 32'd3);
        repeat (4) tick();
        do_start(32'd81, 32'd9);
        wait_hold("t5", NB);
        do_stop(32'd9, 32'd0, 1'b0);

        // Divisor above 2^(NB-1) exercises the carry bit of the trial value.
        do_start(32'hFFFF_FFFF, 32'h8000_0001);
        wait_hold("t7", NB);
        do_stop(32'd1, 32'h7FFF_FFFE, 1'b0);

        // Reset mid-RUN zeroes everything; a later stop is ignored.
        do_start(32'd1000, 32'd10);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_done", {31'b0, done}, 32'd0);
        check("t6_quotient", quotient, 32'd0);
        check("t6_rest", rest, 32'd0);
        check("t6_dbz", {31'b0, dbz}, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("t6_no_valid", {31'b0, valid}, 32'd0);
        check("t6_idle", {31'b0, done}, 32'd0);
        check("t6_quot_zero", quotient, 32'd0);

        repeat (2) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
